// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO drain arbiter: beat field positions,
// FSM encoding and the default urgency threshold.
package fifo_drain_pkg;

  localparam int SOP_BIT   = 32;
  localparam int EOP_BIT   = 33;
  localparam int EMPTY_LSB = 34;
  localparam int ERR_BIT   = 36;

  localparam int URGENT_LEVEL_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_drain_arbiter_rr_urgent_picker.sv
// Combinational round-robin picker: the urgent subset of the candidates,
// when non-empty, replaces the full candidate set before the rotating search.
module rr_urgent_picker #(
  parameter int NUM_CH   = 4,
  parameter int CH_WIDTH = 2
) (
  input  logic [NUM_CH-1:0]   cand_i,
  input  logic [NUM_CH-1:0]   urgent_i,
  input  logic [CH_WIDTH-1:0] rr_ptr_i,
  output logic [CH_WIDTH-1:0] grant_o,
  output logic                found_o
);

  // One extra bit so rr_ptr + offset never overflows before the wrap compare.
  localparam int SW = CH_WIDTH + 1;

  logic [NUM_CH-1:0] hot;
  logic [NUM_CH-1:0] pool;
  logic [SW-1:0]     idx;

  assign hot  = cand_i & urgent_i;
  assign pool = (|hot) ? hot : cand_i;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    found_o = 1'b0;
    grant_o = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, rr_ptr_i} + SW'(k);
      if (idx >= SW'(NUM_CH)) idx = idx - SW'(NUM_CH);
      if (!found_o && pool[idx[CH_WIDTH-1:0]]) begin
        found_o = 1'b1;
        grant_o = idx[CH_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Packet-atomic drain of NUM_CH source FIFOs into one registered Avalon-ST
// output stage; round-robin with fill-level urgency, grant held until eop.
module fifo_drain_arbiter
  import fifo_drain_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 37,
  parameter int FILL_WIDTH   = 4,
  parameter int URGENT_LEVEL = URGENT_LEVEL_DEFAULT,
  parameter int CH_WIDTH     = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          src_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_CH*FILL_WIDTH-1:0] src_fill_level,
  output logic [NUM_CH-1:0]          src_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic [CH_WIDTH-1:0]        grant_ch,
  output logic                       busy
);

  state_e                state_q, state_d;
  logic [CH_WIDTH-1:0]   grant_q, grant_d;
  logic [CH_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic [NUM_CH-1:0]     urgent;
  logic [CH_WIDTH-1:0]   pick;
  logic                  pick_found;
  logic                  load_en;
  logic                  xfer_ready;
  logic                  take;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      urgent[i] = src_fill_level[i*FILL_WIDTH +: FILL_WIDTH] >= FILL_WIDTH'(URGENT_LEVEL);
    end
  end

  rr_urgent_picker #(
    .NUM_CH   (NUM_CH),
    .CH_WIDTH (CH_WIDTH)
  ) u_picker (
    .cand_i   (src_valid),
    .urgent_i (urgent),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick),
    .found_o  (pick_found)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CH_WIDTH'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is offered whenever the output register can load; it must not
  // depend on src_valid, so a drained FIFO simply sees ready held high.
  assign load_en    = !out_valid_q || out_ready;
  assign xfer_ready = (state_q == XFER) && load_en;
  assign take       = xfer_ready && sel_valid;

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      src_ready[i] = xfer_ready && (grant_q == CH_WIDTH'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: if (|src_valid) state_d = ARB;
      ARB: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (take && sel_data[EOP_BIT]) begin
          rr_ptr_d = (grant_q == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (load_en) begin
      out_valid_q <= take;
      if (take) out_data_q <= sel_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_ch  = grant_q;
  assign busy      = (state_q == XFER);

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Packet-atomic scheduler that drains N timing-adapter FIFOs (DEPTH 8, 37-bit beats) into one Avalon-ST output stage of the DE4_SOPC fabric.
- Arbitration is round-robin, with an urgency override driven by each FIFO's fill_level.
- Once granted, a channel holds the output until its end-of-packet beat has been accepted.

Parameters:
- NUM_CH, 4, number of source FIFOs (2..8).
- DATA_WIDTH, 37, beat width; bits [31:0] payload, [32] sop, [33] eop, [35:34] empty, [36] error.
- FILL_WIDTH, 4, width of each fill_level input (0..8).
- URGENT_LEVEL, 6, fill_level at or above which a channel is urgent.
- CH_WIDTH, 2, width of the channel index (clog2 NUM_CH, minimum 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- src_valid  in  NUM_CH  per-channel FIFO out_valid.
- src_data  in  NUM_CH*DATA_WIDTH  per-channel FIFO out_data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_fill_level  in  NUM_CH*FILL_WIDTH  per-channel FIFO fill_level.
- src_ready  out  NUM_CH  per-channel FIFO out_ready; one-hot or zero.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_WIDTH  output beat.
- out_ready  in  1  downstream ready; ready latency 0.
- grant_ch  out  CH_WIDTH  currently or last granted channel.
- busy  out  1  high while in XFER.

Behaviour:
- Clocking and reset: single clock clk; reset_n is asynchronous, active-low. All state registers use an async clear on negedge reset_n.
- Reset values:
  - out_valid=0, out_data=0.
  - grant_ch=0, busy=0.
  - rr_ptr=0, state=IDLE.
  - src_ready=0 (combinational, forced low in IDLE/ARB).
- Output stage:
  - Single register. load_en = !out_valid || out_ready.
  - A beat is taken when src_ready[g] && src_valid[g]; that beat appears on out_data/out_valid the next cycle (latency 1).
  - When out_valid && out_ready and no new beat is taken, out_valid drops to 0.
  - out_data holds its value while out_valid && !out_ready.
- src_ready[g] = (state==XFER) && load_en. All other channels get 0. src_ready never depends on src_valid.
- State machine:
  - IDLE -> ARB when any src_valid is high.
  - ARB (one cycle):
    - Candidates: channels with src_valid.
    - If any candidate has fill_level >= URGENT_LEVEL, the urgent set replaces the candidate set.
    - Pick the first candidate at or after rr_ptr, modulo NUM_CH.
    - Latch grant_ch; go to XFER. If no candidate remains, return to IDLE.
  - XFER: transfer beats from grant_ch. On the accepted beat with eop=1: rr_ptr <= grant_ch+1 (wraps NUM_CH-1 -> 0), then go to IDLE.
- Width and wrap rules:
  - rr_ptr wrap uses an explicit compare to NUM_CH-1, not power-of-2 overflow.
  - fill_level is compared unsigned at full FILL_WIDTH; 8 (FIFO full) is urgent.
- Boundary conditions:
  - Granted channel goes empty mid-packet: remain in XFER with src_ready asserted; no timeout.
  - sop and eop on the same beat: a one-beat packet; leave XFER after it.
  - A beat with sop=1 arriving mid-packet is forwarded unchanged; only eop ends a grant.
  - Urgency changes during XFER: ignored until the next ARB.
  - Downstream stalls: no beat is lost or duplicated; src_ready stays low while out_valid && !out_ready.
  - Reset mid-packet: everything clears at once. Source FIFOs are expected to be reset by the same reset_n.
- Throughput: sustained one beat per cycle within a packet. Packet-to-packet overhead is 2 idle grant cycles (IDLE, ARB).

Decomposition:
- Shared package fifo_drain_pkg:
  - beat field localparams: SOP_BIT=32, EOP_BIT=33, EMPTY_LSB=34, ERR_BIT=36;
  - state encoding IDLE=2'd0, ARB=2'd1, XFER=2'd2;
  - default URGENT_LEVEL.
- One sub-module: rr_urgent_picker. Purely combinational; inputs are the candidate mask, urgent mask and rr_ptr; outputs are the granted index and found flag.

Test Plan:
1. Single channel: ch1 sends a 3-beat packet (data 0x10,0x11,0x12; eop on the third), out_ready=1 -> out_data follows in order starting 3 cycles after src_valid rises; grant_ch=1; busy drops after the third beat; rr_ptr=2.
2. Round-robin: all 4 channels hold 2-beat packets, rr_ptr=0 -> grant order 0,1,2,3,0; each packet contiguous with no interleaving.
3. Urgency: ch0 fill=2, ch2 fill=7, rr_ptr=0 -> ch2 is granted first, then ch0.
4. Backpressure: out_ready toggles 1,0,0,1 during a 4-beat packet -> out_data holds while stalled; exactly 4 beats delivered; src_ready low during stall cycles.
5. Wrap and single-beat packet: rr_ptr=3, only ch3 valid with sop=eop=1 -> one beat delivered; rr_ptr wraps to 0.
6. Reset mid-packet: assert reset_n=0 after beat 2 of 4 -> out_valid=0, busy=0, src_ready=0 immediately (asynchronously); after release, IDLE with rr_ptr=0.
